// File: rtl/instr_encode_pkg.sv
// Shared definitions for the instruction encoder and its matching decoder:
// opcode constants, the fmt field encoding, the encoder FSM state type and
// an immediate range helper.
package instr_encode_pkg;

    // Opcodes shared by encoder and decoder
    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0000011;
    localparam logic [6:0] OPC_S = 7'b0100011;
    localparam logic [6:0] OPC_B = 7'b1100011;
    localparam logic [6:0] OPC_U = 7'b0000111;
    localparam logic [6:0] OPC_J = 7'b1101111;

    // fmt input encoding; codes 6 and 7 are invalid
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // Program-load FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Number of encoded words held between acceptance and the imem write
    localparam int FIFO_DEPTH = 2;

    // True when v is the sign extension of its low 'bits' bits
    function automatic logic fits_signed(input logic [31:0] v, input int bits);
        logic [31:0] hi;
        hi = 32'($signed(v) >>> (bits - 1));
        return (hi == 32'h0000_0000) || (hi == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field-to-word packer. Builds a 32-bit instruction word from
// the field bundle and flags an invalid fmt. With IMM_RANGE_CHECK_EN defined
// it also flags immediates that do not fit the chosen format; the word is
// still produced from the truncated immediate either way.
module instr_pack
    import instr_encode_pkg::*;
(
    input  logic [2:0]  fmt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        err_o
);

    logic fmt_err;
    logic range_err;

    // Field packing per format; invalid fmt produces an all-zero word
    always_comb begin
        word_o  = 32'h0000_0000;
        fmt_err = 1'b0;
        case (fmt_i)
            FMT_R: word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OPC_R};
            FMT_I: word_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_I};
            FMT_S: word_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_S};
            FMT_B: word_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                             imm_i[4:1], imm_i[11], OPC_B};
            FMT_U: word_o = {imm_i[31:12], rd_i, OPC_U};
            FMT_J: word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                             rd_i, OPC_J};
            default: fmt_err = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Flag immediates that lose information when truncated into the word
    always_comb begin
        range_err = 1'b0;
        case (fmt_i)
            FMT_I, FMT_S: range_err = !fits_signed(imm_i, 12);
            FMT_B:        range_err = !fits_signed(imm_i, 13) || imm_i[0];
            FMT_J:        range_err = !fits_signed(imm_i, 21) || imm_i[0];
            FMT_U:        range_err = (imm_i[11:0] != 12'h000);
            default:      range_err = 1'b0;
        endcase
    end
`else
    // Immediates are truncated silently
    assign range_err = 1'b0;
`endif

    assign err_o = fmt_err | range_err;

endmodule

// File: rtl/instr_encode.sv
// Instruction encoder: accepts field bundles over a valid/ready handshake,
// packs them into 32-bit words, buffers them in a 2-entry FIFO and writes
// them to consecutive imem word addresses starting from 0.
// Optional feature: define IMM_RANGE_CHECK_EN to flag out-of-range immediates.
module instr_encode
    import instr_encode_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        fmt,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err,
    output logic              ovf
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]      FILL_FULL = 2'(FIFO_DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic              err_q;
    logic              ovf_q;

    logic [31:0]       mem_q [FIFO_DEPTH];
    logic              rd_ptr_q;
    logic              wr_ptr_q;
    logic [1:0]        fill_q;

    logic [31:0]       pack_word;
    logic              pack_err;
    logic              accept;
    logic              pop;

    instr_pack u_pack (
        .fmt_i    (fmt),
        .rd_i     (rd),
        .rs1_i    (rs1),
        .rs2_i    (rs2),
        .funct3_i (funct3),
        .funct7_i (funct7),
        .imm_i    (imm),
        .word_o   (pack_word),
        .err_o    (pack_err)
    );

    // A start pulse flushes the buffer, so a bundle offered in that same
    // cycle is dropped rather than pushed into the freshly cleared FIFO.
    assign in_ready = (state_q == ST_LOAD) && (fill_q < FILL_FULL);
    assign accept   = in_valid && in_ready && !start;
    assign imem_we  = (fill_q != 2'd0);
    assign pop      = imem_we && imem_ready && !start;

    // Next-state logic; start restarts a load from any state
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_LOAD:  if (accept && in_last) state_d = ST_DRAIN;
                ST_DRAIN: if (fill_q == 2'd0) state_d = ST_DONE;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FIFO storage; contents are only observed while fill is non-zero
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= pack_word;
        end
    end

    // FIFO pointers and fill; simultaneous push and pop keep fill constant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            fill_q   <= 2'd0;
        end else if (start) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            fill_q   <= 2'd0;
        end else begin
            if (accept) wr_ptr_q <= ~wr_ptr_q;
            if (pop)    rd_ptr_q <= ~rd_ptr_q;
            case ({accept, pop})
                2'b10:   fill_q <= fill_q + 2'd1;
                2'b01:   fill_q <= fill_q - 2'd1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Write address, word count and overflow advance on each completed write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (start) begin
            addr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (pop) begin
            addr_q <= addr_q + 1'b1;
            if (addr_q == ADDR_LAST) ovf_q <= 1'b1;
            if (count_q != COUNT_MAX) count_q <= count_q + 1'b1;
        end
    end

    // Sticky error, raised when a flagged bundle is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (start) begin
            err_q <= 1'b0;
        end else if (accept && pack_err) begin
            err_q <= 1'b1;
        end
    end

    assign imem_addr  = addr_q;
    assign imem_wdata = imem_we ? mem_q[rd_ptr_q] : 32'h0000_0000;
    assign busy       = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);
    assign count      = count_q;
    assign err        = err_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_instr_encode.sv
// Directed testbench for instr_encode. A default-width instance and an
// ADDR_W=2 instance share all inputs; the small one is used for wrap checks.
module tb_instr_encode;
    import instr_encode_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [2:0]  fmt = 3'd0;
    logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
    logic [2:0]  funct3 = 3'd0;
    logic [6:0]  funct7 = 7'd0;
    logic [31:0] imm = 32'd0;
    logic        imem_ready = 1'b1;

    logic        in_ready, imem_we, busy, done, err, ovf;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0]  count;

    logic        in_ready2, imem_we2, busy2, done2, err2, ovf2;
    logic [1:0]  imem_addr2;
    logic [31:0] imem_wdata2;
    logic [2:0]  count2;

    int checks = 0;
    int errors = 0;

    logic [31:0] wr_data_q[$];
    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr2_data_q[$];
    logic [1:0]  wr2_addr_q[$];
    int          done_cnt = 0;

    always #5 clk = ~clk;

    instr_encode #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_ready(imem_ready), .busy(busy), .done(done),
        .count(count), .err(err), .ovf(ovf)
    );

    instr_encode #(.ADDR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
        .in_last(in_last), .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .funct7(funct7), .imm(imm), .imem_we(imem_we2), .imem_addr(imem_addr2),
        .imem_wdata(imem_wdata2), .imem_ready(imem_ready), .busy(busy2), .done(done2),
        .count(count2), .err(err2), .ovf(ovf2)
    );

    // Inputs change 1 time unit after posedge, so at negedge the handshake
    // values are those the next posedge will see.
    always @(negedge clk) begin
        if (imem_we && imem_ready) begin
            wr_data_q.push_back(imem_wdata);
            wr_addr_q.push_back(imem_addr);
            $display("write dut  addr %0d data %h", imem_addr, imem_wdata);
        end
        if (imem_we2 && imem_ready) begin
            wr2_data_q.push_back(imem_wdata2);
            wr2_addr_q.push_back(imem_addr2);
        end
        if (done) done_cnt++;
    end

    // Reference decoder immediate extraction
    function automatic logic [31:0] dec_imm(input logic [31:0] w);
        case (w[6:0])
            OPC_I:   return {{20{w[31]}}, w[31:20]};
            OPC_S:   return {{20{w[31]}}, w[31:25], w[11:7]};
            OPC_B:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            OPC_U:   return {w[31:12], 12'h000};
            OPC_J:   return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic set_bundle(input logic [2:0] f, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] im, input logic last);
        fmt = f; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
        in_last = last;
        in_valid = 1'b1;
    endtask

    // Wait (bounded) for the pending bundle to be taken, then drop in_valid
    task automatic wait_accept();
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                check("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send(input logic [2:0] f, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] im, input logic last);
        set_bundle(f, d, s1, s2, f3, f7, im, last);
        wait_accept();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        tick();
        tick();
    endtask

    // Compare the i-th write recorded since base against expected addr/data
    task automatic check_wr(input string tag, input int base, input int i,
                            input logic [7:0] a, input logic [31:0] d);
        if (wr_data_q.size() > base + i) begin
            check({tag, "_addr"}, {24'd0, wr_addr_q[base + i]}, {24'd0, a});
            check({tag, "_data"}, wr_data_q[base + i], d);
        end else begin
            check({tag, "_missing"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        int wb, wb2, db;

        // Reset state
        repeat (3) tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_imem_we", {31'd0, imem_we}, 32'd0);
        rst = 1'b0;
        tick();
        check("rst_addr", {24'd0, imem_addr}, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_count", {23'd0, count}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);

        // Single R instruction, latency 1 to imem_we
        wb = wr_data_q.size(); db = done_cnt;
        do_start();
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_in_ready", {31'd0, in_ready}, 32'd1);
        send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
        check("t1_we_latency", {31'd0, imem_we}, 32'd1);
        check("t1_wdata_head", imem_wdata, 32'h0020_81B3);
        wait_done();
        check("t1_nwr", wr_data_q.size() - wb, 32'd1);
        check_wr("t1_w0", wb, 0, 8'd0, 32'h0020_81B3);
        check("t1_count", {23'd0, count}, 32'd1);
        check("t1_done_pulses", done_cnt - db, 32'd1);
        check("t1_busy_end", {31'd0, busy}, 32'd0);
        $display("t1 R single: count %0d", count);

        // I, S, U sequence with decoder round trip
        wb = wr_data_q.size();
        do_start();
        send(3'd1, 5'd5, 5'd1, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0);
        send(3'd2, 5'd0, 5'd2, 5'd3, 3'd2, 7'd0, 32'd8, 1'b0);
        send(3'd4, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1);
        wait_done();
        check_wr("t2_i", wb, 0, 8'd0, 32'hFFC0_8283);
        check_wr("t2_s", wb, 1, 8'd1, 32'h0031_2423);
        check_wr("t2_u", wb, 2, 8'd2, 32'h1234_5387);
        if (wr_data_q.size() >= wb + 3) begin
            check("t2_i_imm", dec_imm(wr_data_q[wb]), 32'hFFFF_FFFC);
            check("t2_s_imm", dec_imm(wr_data_q[wb + 1]), 32'd8);
        end
        check("t2_count", {23'd0, count}, 32'd3);
        $display("t2 I/S/U: count %0d err %0d", count, err);

        // B imm -8 and J imm 2048 round trip
        wb = wr_data_q.size();
        do_start();
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8, 1'b0);
        send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1);
        wait_done();
        check_wr("t3_b", wb, 0, 8'd0, 32'hFE20_8CE3);
        check_wr("t3_j", wb, 1, 8'd1, 32'h0010_00EF);
        if (wr_data_q.size() >= wb + 2) begin
            check("t3_b_imm", dec_imm(wr_data_q[wb]), 32'hFFFF_FFF8);
            check("t3_j_imm", dec_imm(wr_data_q[wb + 1]), 32'd2048);
        end
        check("t3_err", {31'd0, err}, 32'd0);
        $display("t3 B/J: err %0d", err);

        // Backpressure: imem_ready low, buffer fills at 2
        wb = wr_data_q.size();
        imem_ready = 1'b0;
        do_start();
        send(3'd0, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        send(3'd0, 5'd2, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        set_bundle(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        check("t4_in_ready_full", {31'd0, in_ready}, 32'd0);
        check("t4_no_writes", wr_data_q.size() - wb, 32'd0);
        check("t4_head_word", imem_wdata, 32'h0020_80B3);
        tick();
        imem_ready = 1'b1;
        wait_accept();
        send(3'd0, 5'd4, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
        wait_done();
        check_wr("t4_w0", wb, 0, 8'd0, 32'h0020_80B3);
        check_wr("t4_w1", wb, 1, 8'd1, 32'h0020_8133);
        check_wr("t4_w2", wb, 2, 8'd2, 32'h0020_81B3);
        check_wr("t4_w3", wb, 3, 8'd3, 32'h0020_8233);
        check("t4_count", {23'd0, count}, 32'd4);
        $display("t4 backpressure: %0d writes", wr_data_q.size() - wb);

        // Invalid fmt writes zero and sets err
        wb = wr_data_q.size();
        do_start();
        send(3'd7, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'hFFFF_FFFF, 1'b1);
        wait_done();
        check_wr("t5_inv", wb, 0, 8'd0, 32'h0000_0000);
        check("t5_err", {31'd0, err}, 32'd1);
        $display("t5 invalid fmt: err %0d", err);

        // Five words: wrap on the ADDR_W=2 instance
        wb = wr_data_q.size(); wb2 = wr2_data_q.size();
        do_start();
        check("t6_err_cleared", {31'd0, err}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            send(3'd0, 5'(k), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, (k == 5));
        end
        wait_done();
        check("t6_nwr2", wr2_data_q.size() - wb2, 32'd5);
        if (wr2_data_q.size() >= wb2 + 5) begin
            check("t6_w4_addr2", {30'd0, wr2_addr_q[wb2 + 4]}, 32'd0);
            check("t6_w4_data2", wr2_data_q[wb2 + 4], 32'h0020_82B3);
            check("t6_w3_addr2", {30'd0, wr2_addr_q[wb2 + 3]}, 32'd3);
        end
        check("t6_ovf2", {31'd0, ovf2}, 32'd1);
        check("t6_count2", {29'd0, count2}, 32'd4);
        check("t6_ovf", {31'd0, ovf}, 32'd0);
        check("t6_count", {23'd0, count}, 32'd5);
        check_wr("t6_w4", wb, 4, 8'd4, 32'h0020_82B3);
        $display("t6 wrap: count2 %0d ovf2 %0d", count2, ovf2);

        // I imm 4096: range flag only with the optional check built in
        wb = wr_data_q.size();
        do_start();
        check("t7_ovf_cleared", {31'd0, ovf2}, 32'd0);
        send(3'd1, 5'd5, 5'd1, 5'd0, 3'd0, 7'd0, 32'd4096, 1'b1);
        wait_done();
        check_wr("t7_word", wb, 0, 8'd0, 32'h0000_8283);
`ifdef IMM_RANGE_CHECK_EN
        check("t7_err", {31'd0, err}, 32'd1);
`else
        check("t7_err", {31'd0, err}, 32'd0);
`endif
        $display("t7 imm 4096: err %0d", err);

        // Reset mid-load discards buffered words
        imem_ready = 1'b0;
        do_start();
        send(3'd0, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        send(3'd0, 5'd2, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        imem_ready = 1'b1;
        wb = wr_data_q.size();
        repeat (4) tick();
        check("t8_no_writes", wr_data_q.size() - wb, 32'd0);
        check("t8_we", {31'd0, imem_we}, 32'd0);
        check("t8_busy", {31'd0, busy}, 32'd0);
        check("t8_count", {23'd0, count}, 32'd0);

        // in_valid while idle is ignored
        set_bundle(3'd0, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1);
        repeat (4) @(negedge clk);
        check("t9_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (3) tick();
        check("t9_no_writes", wr_data_q.size() - wb, 32'd0);
        check("t9_busy", {31'd0, busy}, 32'd0);
        $display("t8/t9 reset and idle: writes %0d", wr_data_q.size() - wb);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encode.md
INSTR_ENCODE -- requirements
Module: instr_encode

Interface
REQ-001 Parameter: ADDR_W, default 8, imem word-address width; DEPTH = 2**ADDR_W.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle pulse; begins a program load at word address 0.
REQ-005 in_valid  in  1 / in_ready  out  1  field-bundle handshake; transfer when both high at clk edge.
REQ-006 in_last  in  1  marks final instruction of the program.
REQ-007 fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6-7 invalid.
REQ-008 rd, rs1, rs2  in  5 each; funct3  in  3; funct7  in  7; imm  in  32  raw signed immediate.
REQ-009 imem_we  out  1; imem_addr  out  ADDR_W; imem_wdata  out  32; imem_ready  in  1  write completes when imem_we and imem_ready both high.
REQ-010 busy  out  1; done  out  1; count  out  ADDR_W+1 (words written); err  out  1 (sticky); ovf  out  1 (sticky).

Function
REQ-011 FSM states IDLE, LOAD, DRAIN, DONE; start in any state -> LOAD, clears address, count, err, ovf, buffer.
REQ-012 LOAD -> DRAIN when the in_last transfer is accepted; DRAIN -> DONE when buffer empty; DONE -> IDLE one cycle later.
REQ-013 in_ready = (state==LOAD) and buffer fill < 2, computed from registered fill only.
REQ-014 Opcodes: R 0110011, I 0000011, S 0100011, B 1100011, U 0000111, J 1101111.
REQ-015 R word = {funct7, rs2, rs1, funct3, rd, op}; I = {imm[11:0], rs1, funct3, rd, op}.
REQ-016 S = {imm[11:5], rs2, rs1, funct3, imm[4:0], op}; B = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
REQ-017 U = {imm[31:12], rd, op}; J = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
REQ-018 Invalid fmt: word 32'h0000_0000 written, err set.
REQ-019 Encoded word enters a 2-entry FIFO the cycle after acceptance; imem_we asserts earliest one cycle after acceptance (latency 1).
REQ-020 imem_we = buffer non-empty; imem_addr/imem_wdata = head entry; pop, address increment and count increment only on imem_ready.
REQ-021 Push and pop in the same cycle leave fill unchanged; order preserved.
REQ-022 Address at DEPTH-1 wraps to 0 on write; ovf set; count saturates at DEPTH.
REQ-023 busy = state is LOAD or DRAIN; done is a one-cycle pulse on DRAIN -> DONE.
REQ-024 in_valid outside LOAD is ignored; no transfer occurs.

Reset
REQ-025 rst: state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, busy 0, done 0, count 0, err 0, ovf 0, FIFO empty.
REQ-026 rst mid-load discards buffered words; no further imem writes until next start.

Configuration
REQ-027 Macro IMM_RANGE_CHECK_EN: when defined, err set if I/S imm not sign-extended 12-bit, B imm not signed 13-bit or imm[0]=1, J imm not signed 21-bit or imm[0]=1, U imm[11:0] nonzero; the word is still written, truncated.
REQ-028 Without IMM_RANGE_CHECK_EN: imm silently truncated; err only from invalid fmt.

Structure
REQ-029 Shared package holds the opcode constants, fmt encoding, and FSM state enum; both this block and the decoder use the same opcode constants.
REQ-030 Sub-module instr_pack: combinational field-to-word packer (REQ-015..018, REQ-027); FSM, FIFO and write port stay in instr_encode.

Verification
REQ-031 start; R fmt, funct7=0, rs2=2, rs1=1, funct3=0, rd=3, in_last -> one write addr 0 data 32'h0020_81B3, done pulse, count 1.
REQ-032 I fmt, rs1=1, rd=5, imm=-4 -> data 32'hFFC0_8283; feeding it to the decoder yields immediate 32'hFFFF_FFFC.
REQ-033 B fmt imm=-8, then J fmt imm=2048 -> decoder round-trip immediates -8 and 2048; err stays 0.
REQ-034 imem_ready held low 5 cycles with 4 bundles offered -> in_ready low after 2 accepted; all 4 written in order once released.
REQ-035 ADDR_W=2, 5 instructions -> fifth write at addr 0, ovf 1, count 4.
REQ-036 With IMM_RANGE_CHECK_EN, I fmt imm=4096 -> err 1, word written with imm field 0; without macro, err 0.
